// File: rtl/fetch_sequencer.sv
// Program-counter sequencer: advances, holds, redirects or halts the fetch address; drives IF/ID bubble.
// One-cycle latency on every request; stall/flush bubbles are counted internally, HALTED holds until rst.
module fetch_sequencer #(
  parameter int unsigned RESET_PC    = 0,
  parameter int unsigned IMEM_DEPTH  = 64,
  parameter int unsigned FLUSH_SLOTS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        hlt,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        stall_req,
  input  logic [1:0]  stall_len,
  output logic [31:0] pc,
  output logic [31:0] next_pc,
  output logic        bubble,
  output logic        halted,
  output logic        fault
);

  typedef enum logic [1:0] {RUN, STALL, FLUSH, HALTED} state_t;

  localparam logic [31:0] RST_PC    = 32'(RESET_PC);
  localparam logic [31:0] DEPTH     = 32'(IMEM_DEPTH);
  localparam logic [1:0]  FLUSH_CNT = 2'(FLUSH_SLOTS);

  state_t      state, state_nxt;
  logic [1:0]  cnt, cnt_nxt;
  logic [31:0] pc_nxt;
  logic        fault_nxt;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    pc_nxt    = pc;
    fault_nxt = fault;
    if (state != HALTED) begin
      if (hlt) begin
        state_nxt = HALTED;
      end else if (jump) begin
        if (jump_target < DEPTH) begin
          pc_nxt    = jump_target;
          cnt_nxt   = FLUSH_CNT;
          state_nxt = FLUSH;
        end else begin
          fault_nxt = 1'b1;
          state_nxt = HALTED;
        end
      end else begin
        case (state)
          RUN: begin
            if (stall_req) begin
              cnt_nxt   = (stall_len == 2'd0) ? 2'd1 : stall_len;
              state_nxt = STALL;
            end else begin
              pc_nxt = pc + 32'd1;
            end
          end
          STALL: begin
            // stall_req is deliberately not looked at while already stalled
            if (cnt <= 2'd1) begin
              pc_nxt    = pc + 32'd1;
              cnt_nxt   = 2'd0;
              state_nxt = RUN;
            end else begin
              cnt_nxt = cnt - 2'd1;
            end
          end
          FLUSH: begin
            pc_nxt = pc + 32'd1;
            if (cnt <= 2'd1) begin
              cnt_nxt   = 2'd0;
              state_nxt = RUN;
            end else begin
              cnt_nxt = cnt - 2'd1;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Outputs are registered from the next-state decision so they line up with pc.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= RUN;
      cnt     <= 2'd0;
      pc      <= RST_PC;
      next_pc <= RST_PC + 32'd1;
      bubble  <= 1'b0;
      halted  <= 1'b0;
      fault   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      pc      <= pc_nxt;
      next_pc <= pc_nxt + 32'd1;
      bubble  <= (state_nxt != RUN);
      halted  <= (state_nxt == HALTED);
      fault   <= fault_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: hand-computed pc/bubble/halted/fault after each edge.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hlt = 1'b0;
  logic        jump = 1'b0;
  logic [31:0] jump_target = 32'd0;
  logic        stall_req = 1'b0;
  logic [1:0]  stall_len = 2'd0;
  logic [31:0] pc, next_pc;
  logic        bubble, halted, fault;

  int checks = 0;
  int errors = 0;

  fetch_sequencer #(.RESET_PC(0), .IMEM_DEPTH(64), .FLUSH_SLOTS(2)) dut (
    .clk(clk), .rst(rst), .hlt(hlt), .jump(jump), .jump_target(jump_target),
    .stall_req(stall_req), .stall_len(stall_len), .pc(pc), .next_pc(next_pc),
    .bubble(bubble), .halted(halted), .fault(fault)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    hlt       = 1'b0;
    jump      = 1'b0;
    stall_req = 1'b0;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic expect_st(input string tag, input logic [31:0] epc, input logic eb,
                           input logic eh, input logic ef);
    chk({tag, ".pc"}, pc, epc);
    chk({tag, ".next_pc"}, next_pc, epc + 32'd1);
    chk({tag, ".bubble"}, {31'd0, bubble}, {31'd0, eb});
    chk({tag, ".halted"}, {31'd0, halted}, {31'd0, eh});
    chk({tag, ".fault"}, {31'd0, fault}, {31'd0, ef});
  endtask

  initial begin
    tick();
    expect_st("reset", 32'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    for (int i = 1; i <= 4; i++) begin
      tick();
      expect_st($sformatf("idle%0d", i), i, 1'b0, 1'b0, 1'b0);
    end

    // Redirect at pc=4 to 18, two bubbles, pc=20 when bubble drops
    jump = 1'b1; jump_target = 32'd18;
    tick(); expect_st("jmp18.a", 32'd18, 1'b1, 1'b0, 1'b0);
    tick(); expect_st("jmp18.b", 32'd19, 1'b1, 1'b0, 1'b0);
    tick(); expect_st("jmp18.c", 32'd20, 1'b0, 1'b0, 1'b0);

    jump = 1'b1; jump_target = 32'd5;
    tick(); expect_st("jmp5.a", 32'd5, 1'b1, 1'b0, 1'b0);
    tick(); expect_st("jmp5.b", 32'd6, 1'b1, 1'b0, 1'b0);
    tick(); expect_st("jmp5.c", 32'd7, 1'b0, 1'b0, 1'b0);

    // Stall length 2 at pc=7
    stall_req = 1'b1; stall_len = 2'd2;
    tick(); expect_st("stall2.a", 32'd7, 1'b1, 1'b0, 1'b0);
    stall_req = 1'b1;
    tick(); expect_st("stall2.b", 32'd7, 1'b1, 1'b0, 1'b0);
    tick(); expect_st("stall2.c", 32'd8, 1'b0, 1'b0, 1'b0);

    // stall_len 0 behaves as one cycle
    stall_req = 1'b1; stall_len = 2'd0;
    tick(); expect_st("stall0.a", 32'd8, 1'b1, 1'b0, 1'b0);
    tick(); expect_st("stall0.b", 32'd9, 1'b0, 1'b0, 1'b0);

    // Jump aborts a 3-cycle stall, then a second jump reloads the flush
    stall_req = 1'b1; stall_len = 2'd3;
    tick(); expect_st("stall3", 32'd9, 1'b1, 1'b0, 1'b0);
    jump = 1'b1; jump_target = 32'd13;
    tick(); expect_st("abort13.a", 32'd13, 1'b1, 1'b0, 1'b0);
    tick(); expect_st("abort13.b", 32'd14, 1'b1, 1'b0, 1'b0);
    jump = 1'b1; jump_target = 32'd6;
    tick(); expect_st("reload6.a", 32'd6, 1'b1, 1'b0, 1'b0);
    stall_req = 1'b1; stall_len = 2'd3;
    tick(); expect_st("reload6.b", 32'd7, 1'b1, 1'b0, 1'b0);
    tick(); expect_st("reload6.c", 32'd8, 1'b0, 1'b0, 1'b0);

    // Jump and stall together: redirect wins
    jump = 1'b1; jump_target = 32'd30; stall_req = 1'b1; stall_len = 2'd3;
    tick(); expect_st("jmpstall.a", 32'd30, 1'b1, 1'b0, 1'b0);
    tick(); expect_st("jmpstall.b", 32'd31, 1'b1, 1'b0, 1'b0);
    tick(); expect_st("jmpstall.c", 32'd32, 1'b0, 1'b0, 1'b0);

    // Reset mid-FLUSH
    jump = 1'b1; jump_target = 32'd40;
    tick(); expect_st("jmp40", 32'd40, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick(); expect_st("rst_flush", 32'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Reset mid-STALL
    tick(); expect_st("run1", 32'd1, 1'b0, 1'b0, 1'b0);
    stall_req = 1'b1; stall_len = 2'd3;
    tick(); expect_st("stall_pre_rst", 32'd1, 1'b1, 1'b0, 1'b0);
    rst = 1'b1;
    tick(); expect_st("rst_stall", 32'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Halt and jump together: halt wins, HALTED ignores later requests
    tick(); expect_st("run1b", 32'd1, 1'b0, 1'b0, 1'b0);
    hlt = 1'b1; jump = 1'b1; jump_target = 32'd10;
    tick(); expect_st("hltjmp", 32'd1, 1'b1, 1'b1, 1'b0);
    jump = 1'b1; jump_target = 32'd3; stall_req = 1'b1;
    tick(); expect_st("halted_ign", 32'd1, 1'b1, 1'b1, 1'b0);
    rst = 1'b1;
    tick(); expect_st("rst_halt", 32'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Out-of-range target faults and halts with pc unchanged
    jump = 1'b1; jump_target = 32'd64;
    tick(); expect_st("fault64", 32'd0, 1'b1, 1'b1, 1'b1);
    tick(); expect_st("fault_sticky", 32'd0, 1'b1, 1'b1, 1'b1);
    rst = 1'b1;
    tick(); expect_st("rst_fault", 32'd0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    // Last valid target is fine, and sequential fetch past the end does not fault
    jump = 1'b1; jump_target = 32'd63;
    tick(); expect_st("jmp63", 32'd63, 1'b1, 1'b0, 1'b0);
    tick(); expect_st("seq64", 32'd64, 1'b1, 1'b0, 1'b0);
    tick(); expect_st("seq65", 32'd65, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
